// File: rtl/wall_follower_ctrl.sv
// Wall-following robot controller: synchronised, debounced bump/proximity inputs feeding
// a Moore FSM with a selectable followed side, timed corner turn and rotate-timeout detector.
module wall_follower_ctrl #(
  parameter int DEBOUNCE      = 4,
  parameter int TURN_MAX      = 255,
  parameter int CORNER_CYCLES = 16,
  parameter int CNT_W         = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       head,
  input  logic       side,
  input  logic       side_sel,
  output logic       forward,
  output logic       turn,
  output logic       turn_dir,
  output logic       stuck,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEARCH = 3'd1,
    ROTATE = 3'd2,
    FOLLOW = 3'd3,
    CORNER = 3'd4,
    STUCK  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] TURN_LAST   = CNT_W'(TURN_MAX - 1);
  localparam logic [CNT_W-1:0] CORNER_LAST = CNT_W'(CORNER_CYCLES - 1);

  logic [1:0]       raw;
  logic [1:0]       sync1;
  logic [1:0]       sync2;
  logic [1:0]       filt;
  logic [CNT_W-1:0] deb_cnt [2];
  logic             h;
  logic             s;

  state_t           cur_state;
  state_t           next_state;
  logic             side_lat;
  logic             side_lat_next;
  logic [CNT_W-1:0] turn_cnt;
  logic [CNT_W-1:0] corner_cnt;

  assign raw   = {side, head};
  assign h     = filt[0];
  assign s     = filt[1];
  assign state = cur_state;

  // Index 0 is the head sensor, index 1 the side sensor.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      filt  <= '0;
      for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          filt[i]    <= ~filt[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Losing the wall in FOLLOW outranks a head hit; the corner state then resolves the hit.
  always_comb begin
    next_state    = cur_state;
    side_lat_next = side_lat;
    if (!enable) begin
      next_state = IDLE;
    end else begin
      case (cur_state)
        IDLE: begin
          next_state    = SEARCH;
          side_lat_next = side_sel;
        end
        SEARCH: begin
          if (h)      next_state = ROTATE;
          else if (s) next_state = FOLLOW;
        end
        ROTATE: begin
          if (!h && s)                 next_state = FOLLOW;
          else if (turn_cnt == TURN_LAST) next_state = STUCK;
        end
        FOLLOW: begin
          if (!s)     next_state = CORNER;
          else if (h) next_state = ROTATE;
        end
        CORNER: begin
          if (h)                              next_state = ROTATE;
          else if (s)                         next_state = FOLLOW;
          else if (corner_cnt == CORNER_LAST) next_state = SEARCH;
        end
        STUCK:   next_state = STUCK;
        default: next_state = IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they always match the state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur_state  <= IDLE;
      side_lat   <= 1'b0;
      turn_cnt   <= '0;
      corner_cnt <= '0;
      forward    <= 1'b0;
      turn       <= 1'b0;
      turn_dir   <= 1'b0;
      stuck      <= 1'b0;
    end else begin
      cur_state <= next_state;
      side_lat  <= side_lat_next;

      if (next_state != cur_state) begin
        turn_cnt   <= '0;
        corner_cnt <= '0;
      end else if (cur_state == ROTATE) begin
        turn_cnt <= turn_cnt + 1'b1;
      end else if (cur_state == CORNER) begin
        corner_cnt <= corner_cnt + 1'b1;
      end

      forward  <= 1'b0;
      turn     <= 1'b0;
      turn_dir <= 1'b0;
      stuck    <= 1'b0;
      case (next_state)
        SEARCH, FOLLOW: forward <= 1'b1;
        ROTATE: begin
          turn     <= 1'b1;
          turn_dir <= ~side_lat_next;
        end
        CORNER: begin
          turn     <= 1'b1;
          turn_dir <= side_lat_next;
        end
        STUCK:   stuck <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/wall_follower_ctrl.md
# wall_follower_ctrl

Parametrised wall-following robot controller. It is the next generation of the team's two-sensor wall-follower FSM. It adds input synchronisation and debouncing, a selectable followed side, a timed outside-corner manoeuvre, an enable gate and a rotate-timeout stuck detector. It sits between the raw bump/proximity sensors and the motor drive: `forward`, `turn` and `turn_dir` go straight to the drive stage.

## Interface
Parameters:
- DEBOUNCE, 4: consecutive cycles a synchronised sensor must differ from its filtered value before the filtered value toggles (≥1).
- TURN_MAX, 255: maximum cycles spent in ROTATE before declaring STUCK (≥2).
- CORNER_CYCLES, 16: cycles of the outside-corner turn before giving up and returning to SEARCH (≥1).
- CNT_W, 8: counter width; must satisfy 2^CNT_W > max(DEBOUNCE, TURN_MAX, CORNER_CYCLES).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- enable  in  1  run request; synchronous level.
- head  in  1  raw front-obstacle sensor, asynchronous.
- side  in  1  raw side-wall sensor (mounted on the followed side), asynchronous.
- side_sel  in  1  0 = follow wall on left, 1 = on right; sampled only on IDLE→SEARCH.
- forward  out  1  drive forward.
- turn  out  1  rotate in place.
- turn_dir  out  1  0 = rotate left, 1 = rotate right.
- stuck  out  1  rotate timeout occurred; sticky until IDLE.
- state  out  3  current FSM state code, for debug.

## Operation
- Input path, per sensor: two-flop synchroniser, then debounce counter.
  - The counter increments while the synchroniser output ≠ the filtered value, and clears when they are equal.
  - When the counter reaches DEBOUNCE−1 and the values still differ, the filtered value toggles and the counter clears.
  - Filtered signals are h and s.
- side_lat: the side_sel value registered on the IDLE→SEARCH transition.
- States (codes): IDLE=0, SEARCH=1, ROTATE=2, FOLLOW=3, CORNER=4, STUCK=5. Unused codes go to IDLE on the next edge.
- enable=0 sends every state to IDLE on the next edge. This overrides all other transitions.
- IDLE: enable=1 → SEARCH; side_lat captured.
- SEARCH: h → ROTATE (h has priority over s); else s → FOLLOW; else stay.
- ROTATE: !h & s → FOLLOW; else if turn counter = TURN_MAX−1 → STUCK; else stay and increment the counter.
- FOLLOW: !s → CORNER (s loss has priority over h); else h → ROTATE; else stay.
- CORNER: h → ROTATE; else s → FOLLOW; else if corner counter = CORNER_CYCLES−1 → SEARCH; else stay and increment.
- STUCK: remains until enable=0 (→IDLE) or reset.
- Turn and corner counters clear on every state change; each counts only in its own state.
- Outputs are Moore, decoded from the state register only:
  - IDLE: forward=0, turn=0.
  - SEARCH, FOLLOW: forward=1, turn=0.
  - ROTATE: turn=1, turn_dir=!side_lat (away from the wall).
  - CORNER: turn=1, turn_dir=side_lat (toward the wall).
  - STUCK: forward=0, turn=0, stuck=1.
  - turn_dir=0 whenever turn=0.
  - forward and turn are never both 1.
- stuck is set on entry to STUCK and is cleared only in IDLE or by reset.

## Timing
- Reset (async) values: state=IDLE; forward, turn, turn_dir and stuck = 0; synchronisers, filtered values, side_lat and all counters = 0.
- Reset asserted mid-manoeuvre forces IDLE outputs immediately, without waiting for a clock edge.
- Sensor latency: edge 1 is the first rising edge that samples the new raw value. The filtered value changes at edge DEBOUNCE+2, and the state and outputs change at edge DEBOUNCE+3.
- A pulse at the synchroniser output shorter than DEBOUNCE cycles is ignored.
- enable latency: state and outputs change on the first edge that samples the new enable value.
- ROTATE dwell before STUCK is exactly TURN_MAX cycles.
- CORNER dwell before SEARCH is exactly CORNER_CYCLES cycles.
- Simultaneous h rising and s falling in FOLLOW → CORNER; ROTATE then follows on the next edge, via the CORNER h check.

## Test plan
DEBOUNCE=4, TURN_MAX=20, CORNER_CYCLES=8 throughout.
- Reset, then enable=1 with sensors low → state=1, forward=1 on the 1st edge after enable; all outputs 0 while reset is high.
- side_sel=1, head raised and held → turn=1, turn_dir=0 at edge 7. Then head=0 with side=1 → state=3, forward=1 seven edges later.
- head pulse lasting 3 cycles while in SEARCH → no state change, forward stays 1.
- head held and side never asserted in ROTATE → state=5 and stuck=1 after 20 ROTATE cycles. Then enable=0 → state=0 and stuck=0 on the next edge.
- In FOLLOW with side_sel=0, side drops and stays low → CORNER with turn=1, turn_dir=0 for 8 cycles, then state=1. Repeat with side returning after 3 cycles in CORNER → back to FOLLOW.
- Reset asserted between edges during ROTATE → turn=0 immediately. After release, state=0 and counters=0 even with enable=1 held; SEARCH is reached on the next edge.
